// File: rtl/jtcps15_mbox_pkg.sv
// Shared definitions for the QSound Z80-to-DSP16 command mailbox:
// handshake states, status byte layout and configuration legality.
package jtcps15_mbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ACKW = 2'd3
  } mbox_state_t;

  // Status byte layout as seen by the Z80: {busy, full, empty, ovf, level[3:0]}
  localparam int STAT_BUSY  = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_OVF   = 4;
  localparam int LVL_W      = 4;

  // Legal configurations: DW a whole number of bytes in 8..32, AW 1..8,
  // DEPTH a power of two in 2..8 so the occupancy fits the level field.
  function automatic bit cfg_ok(input int dw, input int aw, input int depth);
    return (dw % 8 == 0) && (dw >= 8) && (dw <= 32) &&
           (aw >= 1) && (aw <= 8) &&
           (depth >= 2) && (depth <= 8) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/jtcps15_mbox_fifo.sv
// Synchronous command FIFO; the head entry is readable combinationally
// whenever the queue is non-empty.
module jtcps15_mbox_fifo
  import jtcps15_mbox_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full queue still accepts a push when an entry leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Pointer and occupancy bookkeeping; flush behaves like a soft reset here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; only the pointers decide what is valid.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtcps15_dsp_mailbox.sv
// Queued Z80-to-DSP16 command mailbox: byte staging, commit into a FIFO,
// IRQ plus two parallel-input reads (address word, then data word) per command.
module jtcps15_dsp_mailbox
  import jtcps15_mbox_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cpu_we,
  input  logic [2:0]    cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_status,
  input  logic          dsp_pids_n,
  input  logic          dsp_iack,
  output logic          dsp_irq,
  output logic [DW-1:0] dsp_pbus_in
);

  localparam int         NB     = DW / 8;
  localparam int         EW     = AW + DW;
  localparam logic [2:0] NB_IDX = 3'(NB);

  if (!cfg_ok(DW, AW, DEPTH)) begin : g_bad_cfg
    $error("jtcps15_dsp_mailbox: unsupported DW/AW/DEPTH combination");
  end

  mbox_state_t      state;
  logic [DW-1:0]    stage;
  logic [AW-1:0]    cur_addr;
  logic [DW-1:0]    cur_data;
  logic             pids_q;
  logic             pids_qq;
  logic             pids_rise;
  logic             commit;
  logic             pop;
  logic             overflow;
  logic             ovf;
  logic [EW-1:0]    head;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic [7:0]       status_next;

  function automatic logic [DW-1:0] zext(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    r[AW-1:0] = a;
    return r;
  endfunction

  assign commit    = cpu_we && (cpu_addr == NB_IDX) && !flush;
  assign pop       = (state == ST_IDLE) && !empty && !dsp_iack && !flush;
  assign overflow  = commit && full && !pop;
  assign pids_rise = pids_q && !pids_qq;

  jtcps15_mbox_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (commit),
    .pop   (pop),
    .din   ({cpu_din[AW-1:0], stage}),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Data staging bytes, lane 0 is the most significant; commits never clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (cpu_we) begin
      for (int i = 0; i < NB; i++)
        if (cpu_addr == 3'(i)) stage[DW-8-8*i +: 8] <= cpu_din;
    end
  end

  // Two-stage copy of the DSP strobe so a rise is seen one cycle after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pids_q  <= 1'b1;
      pids_qq <= 1'b1;
    end else begin
      pids_q  <= dsp_pids_n;
      pids_qq <= pids_q;
    end
  end

  // Delivery handshake: launch with IRQ, step on each strobe rise, wait for IACK low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dsp_irq     <= 1'b0;
      dsp_pbus_in <= '0;
      cur_addr    <= '0;
      cur_data    <= '0;
    end else if (flush) begin
      state       <= ST_IDLE;
      dsp_irq     <= 1'b0;
      dsp_pbus_in <= zext(cur_addr);
    end else begin
      unique case (state)
        ST_IDLE: if (pop) begin
          cur_addr    <= head[EW-1:DW];
          cur_data    <= head[DW-1:0];
          dsp_irq     <= 1'b1;
          dsp_pbus_in <= zext(head[EW-1:DW]);
          state       <= ST_ADDR;
        end
        ST_ADDR: if (pids_rise) begin
          dsp_irq     <= 1'b0;
          dsp_pbus_in <= cur_data;
          state       <= ST_DATA;
        end
        ST_DATA: if (pids_rise) state <= ST_ACKW;
        ST_ACKW: if (!dsp_iack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous status read.
  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (cpu_rd)   ovf <= 1'b0;
  end

  // Status byte assembled from the current internal state.
  always_comb begin
    // NOTE: default every bit first so no path leaves the byte unassigned (no latch).
    status_next             = '0;
    status_next[STAT_BUSY]  = (state != ST_IDLE) || !empty;
    status_next[STAT_FULL]  = full;
    status_next[STAT_EMPTY] = empty;
    status_next[STAT_OVF]   = ovf;
    status_next[LVL_W-1:0]  = level;
  end

  // Registered status, one cycle behind the internal state.
  always_ff @(posedge clk) begin
    if (rst) cpu_status <= 8'h20;
    else     cpu_status <= status_next;
  end

endmodule
